// File: rtl/tile_pkg.sv
// ---------------------------------------------------------------------------
// tile_pkg
// Shared definitions for the tile window loader front-end.
//   PIX_W_DEF       default pixel width in bits
//   W_NW .. W_SE    index of each element inside a 3x3 window (w = 3*dr+dc)
//   state_t         window-side FSM state {S_LOAD, S_EMIT}
//   calcBeats()     number of lane-parallel input beats that fill one tile
//   cntWidth()      counter width for a count range, never narrower than 1
// ---------------------------------------------------------------------------
package tile_pkg;

   localparam int PIX_W_DEF  = 5;
   localparam int WIN_PIXELS = 9;

   localparam int W_NW = 0;
   localparam int W_N  = 1;
   localparam int W_NE = 2;
   localparam int W_W  = 3;
   localparam int W_C  = 4;
   localparam int W_E  = 5;
   localparam int W_SW = 6;
   localparam int W_S  = 7;
   localparam int W_SE = 8;

   typedef enum logic {
      S_LOAD,
      S_EMIT
   } state_t;

   // Input beats needed to fill a TILE_DIM x TILE_DIM tile.
   function automatic int calcBeats(input int tileDim, input int lanes);
      return (tileDim * tileDim) / lanes;
   endfunction

   // $clog2 collapses to zero for a range of one; keep such counters 1 bit wide.
   function automatic int cntWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tile_bank.sv
// ---------------------------------------------------------------------------
// tile_bank
// One TILE_DIM x TILE_DIM pixel store with a lane-parallel write port and a
// combinational 3x3 neighbourhood read.
// Ports:
//   clk     rising-edge clock
//   i_we    write the current beat
//   i_beat  beat number; lane k lands on pixel i_beat*PIXEL_LANES+k
//   i_pix   lane-parallel beat, lane k at [k*PIX_W +: PIX_W]
//   i_row   window centre row (1..TILE_DIM-2)
//   i_col   window centre column (1..TILE_DIM-2)
//   o_win   3x3 window, element 3*dr+dc at [(3*dr+dc)*PIX_W +: PIX_W]
// Contents have no reset; they are always fully rewritten before being read.
// ---------------------------------------------------------------------------
module tile_bank
   import tile_pkg::*;
#(
   parameter int PIX_W       = PIX_W_DEF,
   parameter int PIXEL_LANES = 5,
   parameter int TILE_DIM    = 20,
   parameter int BEAT_W      = 7,
   parameter int RC_W        = 5
) (
   input  logic                          clk,
   input  logic                          i_we,
   input  logic [BEAT_W-1:0]             i_beat,
   input  logic [PIXEL_LANES*PIX_W-1:0]  i_pix,
   input  logic [RC_W-1:0]               i_row,
   input  logic [RC_W-1:0]               i_col,
   output logic [WIN_PIXELS*PIX_W-1:0]   o_win
);

   localparam int NPIX   = TILE_DIM * TILE_DIM;
   localparam int ADDR_W = cntWidth(NPIX);

   logic [PIX_W-1:0] r_mem [NPIX];

   // Store one beat: consecutive lanes fill consecutive row-major pixels.
   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int k = 0; k < PIXEL_LANES; k++) begin
            r_mem[ADDR_W'(int'(i_beat) * PIXEL_LANES + k)] <= i_pix[k*PIX_W +: PIX_W];
         end
      end
   end

   // Gather the neighbourhood whose top-left corner is (row-1, col-1).
   always_comb begin
      o_win = '0;
      for (int dr = 0; dr < 3; dr++) begin
         for (int dc = 0; dc < 3; dc++) begin
            o_win[(W_NW + 3*dr + dc)*PIX_W +: PIX_W] =
               r_mem[ADDR_W'((int'(i_row) + dr - 1) * TILE_DIM + int'(i_col) + dc - 1)];
         end
      end
   end

endmodule

// File: rtl/tile_window_loader.sv
// ---------------------------------------------------------------------------
// tile_window_loader
// Collects PIXEL_LANES pixels per beat into a TILE_DIM x TILE_DIM tile, then
// streams every interior 3x3 window in raster order over valid/ready.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   flush        synchronous clear of all tile state (tile_cnt kept)
//   in_valid     beat present on pixel_in
//   in_ready     loader accepts a beat this cycle
//   pixel_in     lane k at [k*PIX_W +: PIX_W]
//   load_end     a complete tile is held and not yet fully emitted
//   win_valid    win_data holds a window
//   win_ready    consumer takes the window
//   win_data     element 3*dr+dc at [(3*dr+dc)*PIX_W +: PIX_W]
//   win_last     final window of the tile
//   tile_cnt     tiles fully emitted since reset (wraps)
// Build option: define TILE_PINGPONG_EN for two banks so that loading and
// emitting overlap; without it a single bank alternates load and emit.
// ---------------------------------------------------------------------------
module tile_window_loader
   import tile_pkg::*;
#(
   parameter int PIX_W       = PIX_W_DEF,
   parameter int PIXEL_LANES = 5,
   parameter int TILE_DIM    = 20
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [PIXEL_LANES*PIX_W-1:0]  pixel_in,
   output logic                          load_end,
   output logic                          win_valid,
   input  logic                          win_ready,
   output logic [WIN_PIXELS*PIX_W-1:0]   win_data,
   output logic                          win_last,
   output logic [15:0]                   tile_cnt
);

   localparam int BEATS   = calcBeats(TILE_DIM, PIXEL_LANES);
   localparam int OUT_DIM = TILE_DIM - 2;
   localparam int BEAT_W  = cntWidth(BEATS);
   localparam int RC_W    = cntWidth(TILE_DIM);
`ifdef TILE_PINGPONG_EN
   localparam int NB = 2;
`else
   localparam int NB = 1;
`endif

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [RC_W-1:0]   LAST_RC   = RC_W'(OUT_DIM);
   localparam logic [RC_W-1:0]   FIRST_RC  = RC_W'(1);

   state_t                        r_state;
   state_t                        w_stateNext;
   logic [BEAT_W-1:0]             r_beat;
   logic [RC_W-1:0]               r_row;
   logic [RC_W-1:0]               r_col;
   logic [RC_W-1:0]               w_rowNext;
   logic [RC_W-1:0]               w_colNext;
   logic [1:0]                    r_full;
   logic                          r_loadBank;
   logic                          r_emitBank;
   logic                          w_emitNext;
   logic [WIN_PIXELS*PIX_W-1:0]   r_winData;
   logic [15:0]                   r_tileCnt;
   logic                          w_accept;
   logic                          w_lastBeat;
   logic                          w_hs;
   logic                          w_atEnd;
   logic                          w_lastHs;
   logic                          w_loadWin;
   logic                          w_otherFull;
   logic [WIN_PIXELS*PIX_W-1:0]   w_bankWin [2];
   logic [WIN_PIXELS*PIX_W-1:0]   w_rdWin;

   assign w_accept    = in_valid && in_ready;
   assign w_lastBeat  = w_accept && (r_beat == LAST_BEAT);
   assign w_hs        = win_valid && win_ready;
   assign w_atEnd     = (r_row == LAST_RC) && (r_col == LAST_RC);
   assign w_lastHs    = w_hs && w_atEnd;
   assign w_otherFull = (NB == 2) && r_full[!r_emitBank];

   assign win_data = r_winData;
   assign tile_cnt = r_tileCnt;

   // S_LOAD means no window is being presented. A full bank spends one
   // priming cycle here so that win_data can be registered from its (1,1)
   // window. In S_EMIT each accepted window pre-reads the next one, and after
   // the last window a full second bank is entered directly without priming.
   always_comb begin
      w_stateNext = r_state;
      w_rowNext   = r_row;
      w_colNext   = r_col;
      w_emitNext  = r_emitBank;
      w_loadWin   = 1'b0;
      in_ready    = !r_full[r_loadBank];
      load_end    = |r_full;
      win_valid   = (r_state == S_EMIT);
      win_last    = (r_state == S_EMIT) && w_atEnd;
      case (r_state)
         S_LOAD: begin
            if (r_full[r_emitBank]) begin
               w_stateNext = S_EMIT;
               w_loadWin   = 1'b1;
            end
         end
         S_EMIT: begin
            if (win_ready) begin
               w_loadWin = 1'b1;
               if (w_atEnd) begin
                  w_rowNext  = FIRST_RC;
                  w_colNext  = FIRST_RC;
                  w_emitNext = (NB == 2) ? !r_emitBank : r_emitBank;
                  if (!w_otherFull) begin
                     w_stateNext = S_LOAD;
                     w_loadWin   = 1'b0;
                  end
               end else if (r_col == LAST_RC) begin
                  w_colNext = FIRST_RC;
                  w_rowNext = r_row + 1'b1;
               end else begin
                  w_colNext = r_col + 1'b1;
               end
            end
         end
         default: w_stateNext = S_LOAD;
      endcase
   end

   // Banks are read at the coordinates that will be current after this edge,
   // which is what lets win_data change on the same edge as the handshake.
   for (genvar b = 0; b < 2; b++) begin : g_bank
      if (b < NB) begin : g_inst
         tile_bank #(
            .PIX_W       (PIX_W),
            .PIXEL_LANES (PIXEL_LANES),
            .TILE_DIM    (TILE_DIM),
            .BEAT_W      (BEAT_W),
            .RC_W        (RC_W)
         ) u_bank (
            .clk    (clk),
            .i_we   (w_accept && (r_loadBank == 1'(b))),
            .i_beat (r_beat),
            .i_pix  (pixel_in),
            .i_row  (w_rowNext),
            .i_col  (w_colNext),
            .o_win  (w_bankWin[b])
         );
      end else begin : g_none
         assign w_bankWin[b] = '0;
      end
   end

   assign w_rdWin = w_bankWin[w_emitNext];

   // State, counters and bank bookkeeping. Flush clears everything except
   // the emitted-tile count and wins over any beat or window handshake.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_LOAD;
         r_beat     <= '0;
         r_row      <= FIRST_RC;
         r_col      <= FIRST_RC;
         r_full     <= '0;
         r_loadBank <= 1'b0;
         r_emitBank <= 1'b0;
         r_winData  <= '0;
         r_tileCnt  <= '0;
      end else if (flush) begin
         r_state    <= S_LOAD;
         r_beat     <= '0;
         r_row      <= FIRST_RC;
         r_col      <= FIRST_RC;
         r_full     <= '0;
         r_loadBank <= 1'b0;
         r_emitBank <= 1'b0;
         r_winData  <= '0;
      end else begin
         r_state    <= w_stateNext;
         r_row      <= w_rowNext;
         r_col      <= w_colNext;
         r_emitBank <= w_emitNext;
         if (w_loadWin) begin
            r_winData <= w_rdWin;
         end
         if (w_lastHs) begin
            r_tileCnt <= r_tileCnt + 16'd1;
         end
         if (w_accept) begin
            if (w_lastBeat) begin
               r_beat     <= '0;
               r_loadBank <= (NB == 2) ? !r_loadBank : r_loadBank;
            end else begin
               r_beat <= r_beat + 1'b1;
            end
         end
         for (int b = 0; b < 2; b++) begin
            if (w_lastBeat && (r_loadBank == 1'(b))) begin
               r_full[b] <= 1'b1;
            end else if (w_lastHs && (r_emitBank == 1'(b))) begin
               r_full[b] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: doc/tile_window_loader.md
Name: tile_window_loader

Overview:
- Parametrised input front-end for the edge-detection datapath.
- Accepts lane-parallel pixel beats, PIXEL_LANES pixels per clock, and assembles one TILE_DIM x TILE_DIM tile.
- Once the tile is complete, streams every interior 3x3 neighbourhood in raster order to the filter pipeline over a valid/ready handshake.
- Replaces the fixed 5-lane, 80-beat, 18x18 load/pause scheme with a generic one.

Parameters:
- PIX_W, 5, bits per pixel
- PIXEL_LANES, 5, pixels per input beat; TILE_DIM*TILE_DIM must be divisible by PIXEL_LANES
- TILE_DIM, 20, tile edge length in pixels, minimum 3
- BEATS (localparam), TILE_DIM*TILE_DIM/PIXEL_LANES, input beats per tile (80 at defaults)
- OUT_DIM (localparam), TILE_DIM-2, window centres per row/column (18 at defaults)

Ports:
- clk, input, 1, rising-edge clock
- reset, input, 1, asynchronous active-high reset
- flush, input, 1, synchronous clear of all tile state
- in_valid, input, 1, pixel beat present
- in_ready, output, 1, loader accepts a beat this cycle
- pixel_in, input, PIXEL_LANES*PIX_W, lane k at bits [k*PIX_W +: PIX_W]
- load_end, output, 1, a complete tile is held and not yet fully emitted
- win_valid, output, 1, win_data is valid
- win_ready, input, 1, consumer accepts the window
- win_data, output, 9*PIX_W, window element w at bits [w*PIX_W +: PIX_W]; w = 3*dr+dc, where dr,dc in 0..2 are offsets from (r-1,c-1)
- win_last, output, 1, asserted with the final window of a tile
- tile_cnt, output, 16, tiles fully emitted since reset, wraps modulo 2^16

Behaviour:
- Reset and flush: in_ready=1, load_end=0, win_valid=0, win_last=0, win_data=0, beat counter=0, row/col=1. Reset also clears tile_cnt=0; flush leaves tile_cnt unchanged. Buffer contents are don't-care.
- Beat acceptance: a beat is accepted when in_valid&&in_ready at a rising edge. Beat b writes tile pixels b*PIXEL_LANES+k, k=0..PIXEL_LANES-1, in row-major order (pixel index p = row*TILE_DIM+col).
- FSM LOAD: in_ready=1. On acceptance of beat BEATS-1, the next state is EMIT and load_end=1 from the following cycle.
- FSM EMIT: in_ready=0; in_valid is ignored and no data is written.
  - Cycle 1 of EMIT: win_valid=1 with centre (1,1).
  - Window handshake: each win_valid&&win_ready advances the centre (r,c) in raster order over r,c=1..OUT_DIM and updates win_data on the same edge. win_valid stays 1 between windows, giving one window per cycle under continuous ready.
  - Back-pressure: while win_valid&&!win_ready, win_data, win_last, r and c hold stable.
  - Last window: win_last=1 only at centre (OUT_DIM,OUT_DIM). On its handshake: win_valid=0, load_end=0, tile_cnt+1, next state LOAD with in_ready=1 the next cycle.
- Latency: last input beat at edge N gives first window valid after edge N+1. Minimum tile period is BEATS + OUT_DIM^2 + 1 cycles.
- flush precedence: flush overrides any simultaneous beat or window handshake. A partial tile is discarded.
- Asynchronous reset: reset asserted mid-LOAD or mid-EMIT returns to LOAD immediately, with no glitch-free requirement on win_data.
- Widths: the beat counter is $clog2(BEATS) bits and the row/col counters are $clog2(TILE_DIM) bits. No arithmetic is applied to pixel values.

Optional Feature:
- Macro: TILE_PINGPONG_EN.
- Defined: two tile banks are instantiated.
  - LOAD and EMIT run concurrently on opposite banks. in_ready=0 only when both banks are full.
  - After win_last of bank A, bank B, if full, begins emitting the next cycle with no bubble.
  - load_end is high whenever at least one full bank is un-emitted.
  - Flush clears both banks.
- Undefined: one bank only; behaviour is exactly as above.

Decomposition:
- Shared package tile_pkg: PIX_W default, the window index constants W_NW..W_SE (0..8), the FSM state typedef {S_LOAD, S_EMIT}, and a BEATS calculation function.
- Sub-module tile_bank: a TILE_DIM*TILE_DIM register array with a PIXEL_LANES-wide write port and a combinational 3x3 read at (r,c). It is instantiated once, or twice under TILE_PINGPONG_EN.

Test Plan:
- Reset, then 80 beats where pixel p=p mod 32 (defaults), win_ready=1 → first window centre (1,1): w0=0, w4=21, w8=10 (42 mod 32). Exactly 324 windows follow; win_last only on the 324th; tile_cnt=1; in_ready returns 1 the cycle after.
- Random win_ready low 50% of cycles → win_data is stable across every stall, 324 windows arrive in order, no duplicates or drops.
- in_valid held high throughout EMIT (single bank) → no writes occur; the second tile, loaded after emission, yields windows matching its own data only.
- flush asserted after beat 40 → in_ready=1, load_end=0; 80 new beats then produce a correct full tile; tile_cnt unchanged by the flush.
- Asynchronous reset pulse mid-EMIT at window 100 → win_valid=0 immediately, tile_cnt=0, and the next full tile emits from (1,1).
- TILE_PINGPONG_EN, back-to-back tiles with constant win_ready=1 → win_valid has no gap between tile 1 win_last and tile 2 centre (1,1); tile_cnt=2.
